golden_answer_gen: RTL
======================

// Module: golden_answer_gen
// PURPOSE
//   Self-test stimulus source and golden-answer generator for the systolic-array BIST path.
//   - Streams PATTERN_COUNT weight/activation pairs to the array feeder over a valid/ready handshake.
//   - Computes each pattern's expected column partial sum and delays it by ARRAY_LATENCY cycles.
//   - Presents correct_answer to the comparator in the same cycle as the array's column outputs.
// PARAMETERS
//   SYSTOLIC_SIZE     8    PEs per column; every column accumulates SYSTOLIC_SIZE identical products
//   WEIGHT_WIDTH      8    weight bits, unsigned
//   ACTIVATION_WIDTH  8    activation bits, unsigned
//   PARTIAL_SUM_WIDTH W+A+$clog2(SYSTOLIC_SIZE)  golden answer width
//   PATTERN_COUNT     4    patterns per test run, >=1
//   ARRAY_LATENCY     15   cycles from pattern acceptance to array column output, >=1
//   WEIGHT_SEED/STEP  3/1  weight for pattern p = (SEED + p*STEP) mod 2^WEIGHT_WIDTH
//   ACT_SEED/STEP     5/2  activation for pattern p = (SEED + p*STEP) mod 2^ACTIVATION_WIDTH
// PORTS
//   clk              in   1      system clock
//   rst_n            in   1      asynchronous active-low reset
//   start            in   1      one-cycle request to begin a run (honoured only in IDLE)
//   abort            in   1      synchronous flush; highest priority after reset
//   pattern_valid    out  1      weight_out/activation_out valid
//   pattern_ready    in   1      feeder accepts pattern when valid&ready
//   weight_out       out  W      current weight
//   activation_out   out  A      current activation
//   correct_answer   out  PSW    golden partial sum, aligned to array output
//   answer_valid     out  1      correct_answer valid this cycle
//   answer_index     out  clog2(PATTERN_COUNT) (min 1)  pattern number of correct_answer
//   busy             out  1      high in STREAM or DRAIN
//   done             out  1      one-cycle pulse at run completion
//   compared_results in   S      per-column mismatch flags from comparator (used only with FAULT_LOG_EN)
//   fault_map        out  S      sticky per-column fault flags
// BEHAVIOUR
//   - Reset: all outputs 0, FSM=IDLE, pattern counter 0, delay-line valid bits 0.
//   - FSM IDLE -> STREAM on start. Pattern counter cleared to 0; fault_map cleared.
//   - STREAM: pattern_valid=1.
//     - weight_out/activation_out are held stable while valid&!ready.
//     - Handshake with counter==PATTERN_COUNT-1 -> DRAIN; otherwise counter increments.
//   - DRAIN -> DONE when every delay-line valid bit is 0.
//   - DONE: done=1 for exactly one cycle, then -> IDLE.
//   - start is ignored outside IDLE. start and abort in the same cycle: abort wins, stay IDLE.
//   - abort in any state: next cycle IDLE, pattern_valid=0, delay line flushed, no done pulse. fault_map is held.
//   - Golden value = SYSTOLIC_SIZE * w * a, unsigned, zero-extended to PSW.
//     - Never overflows (max 255*255*8 = 520200 < 2^19).
//     - Computed combinationally at handshake; no pipeline reg before the delay line.
//   - Delay line: ARRAY_LATENCY stages of {valid, index, answer}, free-running (no backpressure).
//     - An entry pushed on a handshake in cycle t appears on the outputs in cycle t+ARRAY_LATENCY.
//     - Back-to-back handshakes give back-to-back answer_valid.
//   - correct_answer and answer_index are held at their last value when answer_valid=0.
//   - Reset asserted mid-run: immediate return to reset state; no partial outputs survive.
// CONFIGURATION
//   GOLDEN_FAULT_LOG_EN defined:
//     - fault_map[i] |= compared_results[i] on every cycle answer_valid=1.
//     - fault_map is cleared on start and on reset only.
//   GOLDEN_FAULT_LOG_EN undefined:
//     - Ports remain present. fault_map is tied 0 and compared_results is ignored (no logic, no flops).
// TESTING
//   1 Reset, start, ready=1 every cycle.
//     -> Patterns (3,5),(4,7),(5,9),(6,11) on consecutive cycles.
//     -> answer_valid 15 cycles after each acceptance, answers 120, 224, 360, 528 with index 0-3.
//     -> done exactly once after the last answer, then busy=0.
//   2 Hold ready=0 for 3 cycles during pattern 1.
//     -> weight_out=4 / activation_out=7 stable throughout.
//     -> answer 224 arrives 15 cycles after the actual handshake.
//     -> answer_valid gap matches the stall.
//   3 SEEDs=8'hFF, STEP=0, PATTERN_COUNT=1 -> correct_answer=520200 (no truncation).
//   4 Assert abort during DRAIN.
//     -> Next cycle IDLE, answer_valid stays 0, no done pulse.
//     -> A subsequent start restarts at pattern 0.
//   5 Pulse start while busy -> ignored; pattern sequence and counter unaffected.
//   6 GOLDEN_FAULT_LOG_EN defined, compared_results=8'h04 on answer 2 only.
//     -> fault_map=8'h04 after answer 2 and persists through done.
//     -> fault_map=0 after the next start.
//     -> Macro undefined: fault_map=0 always.

Source files
------------

// File: rtl/golden_answer_gen_if.sv
// Pattern-feed and golden-answer bus between the BIST answer generator,
// the array feeder and the column comparator.
interface golden_answer_gen_if #(
  parameter int W    = 8,
  parameter int A    = 8,
  parameter int PSW  = 19,
  parameter int IDXW = 2
);
  logic            pattern_valid;
  logic            pattern_ready;
  logic [W-1:0]    weight_out;
  logic [A-1:0]    activation_out;
  logic [PSW-1:0]  correct_answer;
  logic            answer_valid;
  logic [IDXW-1:0] answer_index;

  modport master (
    output pattern_valid, weight_out, activation_out,
    output correct_answer, answer_valid, answer_index,
    input  pattern_ready
  );

  modport slave (
    input  pattern_valid, weight_out, activation_out,
    input  correct_answer, answer_valid, answer_index,
    output pattern_ready
  );
endinterface

// File: rtl/golden_answer_gen.sv
// BIST stimulus source and latency-aligned golden partial-sum generator for the systolic array.
// Optional sticky per-column fault logging is enabled by defining GOLDEN_FAULT_LOG_EN.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_STREAM | offering patterns to the feeder
// ST_DRAIN  | all patterns accepted, waiting for the delay line to empty
// ST_DONE   | one-cycle completion pulse
module golden_answer_gen #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int PATTERN_COUNT     = 4,
  parameter int ARRAY_LATENCY     = 15,
  parameter int WEIGHT_SEED       = 3,
  parameter int WEIGHT_STEP       = 1,
  parameter int ACT_SEED          = 5,
  parameter int ACT_STEP          = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  golden_answer_gen_if.master      bus,
  input  logic [SYSTOLIC_SIZE-1:0] compared_results,
  output logic [SYSTOLIC_SIZE-1:0] fault_map,
  output logic                     busy,
  output logic                     done
);
  localparam int IDX_WIDTH = (PATTERN_COUNT > 1) ? $clog2(PATTERN_COUNT) : 1;
  localparam int PSW       = PARTIAL_SUM_WIDTH;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]                  state;
  logic [IDX_WIDTH-1:0]        pat_cnt;
  logic                        handshake;
  logic                        start_ok;
  logic                        line_empty;
  logic [WEIGHT_WIDTH-1:0]     weight_cur;
  logic [ACTIVATION_WIDTH-1:0] act_cur;
  logic [PSW-1:0]              golden;

  logic                 dl_valid  [ARRAY_LATENCY];
  logic [IDX_WIDTH-1:0] dl_index  [ARRAY_LATENCY];
  logic [PSW-1:0]       dl_answer [ARRAY_LATENCY];
  logic                 src_valid  [ARRAY_LATENCY];
  logic [IDX_WIDTH-1:0] src_index  [ARRAY_LATENCY];
  logic [PSW-1:0]       src_answer [ARRAY_LATENCY];

  // Patterns are an arithmetic sequence; the mod 2^W wrap falls out of the truncating cast.
  assign weight_cur = WEIGHT_WIDTH'(WEIGHT_SEED + int'(pat_cnt) * WEIGHT_STEP);
  assign act_cur    = ACTIVATION_WIDTH'(ACT_SEED + int'(pat_cnt) * ACT_STEP);
  assign golden     = PSW'(SYSTOLIC_SIZE) * PSW'(weight_cur) * PSW'(act_cur);

  assign handshake = (state == ST_STREAM) && bus.pattern_ready && !abort;
  assign start_ok  = (state == ST_IDLE) && start && !abort;

  assign bus.pattern_valid  = (state == ST_STREAM);
  assign bus.weight_out     = (state == ST_STREAM) ? weight_cur : '0;
  assign bus.activation_out = (state == ST_STREAM) ? act_cur : '0;
  assign busy               = (state == ST_STREAM) || (state == ST_DRAIN);
  assign done               = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pat_cnt <= '0;
    end else if (abort) begin
      state   <= ST_IDLE;
      pat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_STREAM;
            pat_cnt <= '0;
          end
        end
        ST_STREAM: begin
          if (bus.pattern_ready) begin
            if (pat_cnt == IDX_WIDTH'(PATTERN_COUNT - 1)) state <= ST_DRAIN;
            else pat_cnt <= pat_cnt + 1'b1;
          end
        end
        ST_DRAIN: if (line_empty) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    src_valid[0]  = handshake;
    src_index[0]  = pat_cnt;
    src_answer[0] = golden;
    for (int k = 1; k < ARRAY_LATENCY; k++) begin
      src_valid[k]  = dl_valid[k-1];
      src_index[k]  = dl_index[k-1];
      src_answer[k] = dl_answer[k-1];
    end
  end

  always_comb begin
    line_empty = 1'b1;
    for (int k = 0; k < ARRAY_LATENCY; k++) begin
      if (dl_valid[k]) line_empty = 1'b0;
    end
  end

  // The last stage doubles as the output register: it only loads real answers so the
  // comparator sees the previous answer held while answer_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ARRAY_LATENCY; k++) begin
        dl_valid[k]  <= 1'b0;
        dl_index[k]  <= '0;
        dl_answer[k] <= '0;
      end
    end else begin
      for (int k = 0; k < ARRAY_LATENCY; k++) begin
        dl_valid[k] <= src_valid[k] && !abort;
        if ((k != ARRAY_LATENCY - 1) || (src_valid[k] && !abort)) begin
          dl_index[k]  <= src_index[k];
          dl_answer[k] <= src_answer[k];
        end
      end
    end
  end

  assign bus.answer_valid   = dl_valid[ARRAY_LATENCY-1];
  assign bus.answer_index   = dl_index[ARRAY_LATENCY-1];
  assign bus.correct_answer = dl_answer[ARRAY_LATENCY-1];

`ifdef GOLDEN_FAULT_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_map <= '0;
    end else if (start_ok) begin
      fault_map <= '0;
    end else if (bus.answer_valid && !abort) begin
      fault_map <= fault_map | compared_results;
    end
  end
`else
  logic unused_compared;
  assign unused_compared = ^{compared_results, start_ok};
  assign fault_map       = '0;
`endif

endmodule
